adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, multi-lane successor to the single-cycle 4-bit adder.
- Adds LANES independent unsigned lanes, each computing add, subtract or accumulate.
- Two-stage registered pipeline with valid/ready handshake on both sides and optional saturation.
- Sits between an operand producer and a result consumer in the datapath; the consumer may stall.

Parameters:
WIDTH, 4, operand width per lane (bits), 2..32
OUT_W, 7, result/accumulator width per lane, must be >= WIDTH+1
LANES, 1, number of independent lanes, 1..8
SATURATE, 0, 0 = wrap modulo 2^OUT_W; 1 = clamp to [0, 2^OUT_W-1]

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
op  input  2  00 ADD, 01 SUB, 10 ACC (acc += a+b), 11 LOAD (acc = a+b)
a  input  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH], unsigned
b  input  LANES*WIDTH  same packing as a
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
c  output  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
ovf  output  LANES  per-lane overflow/underflow flag for the beat on c

Behaviour:
- Reset (reset low, asynchronous assert, synchronous deassert at the system level):
  - s1_v = s2_v = 0; out_valid = 0.
  - c = RV_C (all lanes 0); ovf = 0; every accumulator = 0.
  - in_ready is 1 in the first cycle after deassert.
- Handshake:
  - Input beat transfers when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - in_valid does not depend on in_ready.
  - c, ovf and out_valid hold stable while out_valid && !out_ready.
- Pipeline:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv, combinational from out_ready and the valid registers only.
  - Latency: beat accepted in cycle N appears with out_valid=1 in cycle N+2 when unstalled.
  - Full throughput: one beat per cycle.
  - Capacity: 2 beats. With out_ready low, two beats are accepted, then in_ready = 0.
- Stage 1 registers a, b, op. Operands are zero-extended to OUT_W+1 bits.
- Stage 2 computes the result on the s1->s2 transfer:
  - ADD: r = a+b.
  - SUB: r = a-b.
  - ACC: r = acc+a+b, then acc <= result.
  - LOAD: r = a+b, then acc <= result.
- Accumulator:
  - Updated only on the s1->s2 transfer, so back-to-back ACC beats chain correctly with no hazard.
  - ADD and SUB leave acc unchanged.
- Overflow and saturation:
  - ovf = 1 when r > 2^OUT_W-1, or r < 0 for SUB.
  - SATURATE=0: result = r mod 2^OUT_W.
  - SATURATE=1: overflow gives 2^OUT_W-1; SUB underflow gives 0.
  - Under SATURATE=1, acc stores the clamped value.
- Lanes are fully independent. All lanes share the handshake and op.
- Boundary conditions:
  - Simultaneous input and output transfer with both stages full: both transfers happen and occupancy stays 2.
  - Reset mid-operation: all in-flight beats are dropped and accumulators return to 0. No partial beat is emitted.
  - in_valid while in_ready = 0: the beat is not taken and the producer must hold it.

Decomposition:
- Package pa_adder_pipe:
  - op enum typedef op_e (OP_ADD, OP_SUB, OP_ACC, OP_LOAD).
  - Reset value constant RV_C = '0.
  - Lane-width helper localparams.
- Sub-module adder_pipe_lane:
  - One lane: zero-extend, add/sub, accumulator register, saturate/wrap, ovf.
  - Instantiated LANES times via generate.
- Handshake and valid registers stay in the top module.

Test Plan:
1. Reset: hold reset low 3 cycles with in_valid=1 -> out_valid=0, c=0, ovf=0; in_ready=1 on the first cycle after release.
2. Latency: LANES=2, SATURATE=0, ADD beat a={4'd9,4'd15}, b={4'd3,4'd15} with out_ready=1 -> exactly 2 cycles later c={7'd12,7'd30}, ovf=00.
3. Accumulate: LOAD a=5,b=0, then ACC 15+15 ×4 back-to-back -> results 5,35,65,95,125, ovf=0. Next ACC 15+15 -> SATURATE=0 gives 27 with ovf=1; SATURATE=1 gives 127 with ovf=1.
4. Subtract: SUB a=3,b=7 -> SATURATE=0 gives 124 with ovf=1; SATURATE=1 gives 0 with ovf=1. SUB a=7,b=3 gives 4 with ovf=0.
5. Backpressure: out_ready=0, drive 4 beats -> only 2 accepted and in_ready=0; c stable. Raise out_ready -> 4 results in order, no loss or duplication.
6. Reset mid-stream: assert reset with 2 beats in flight and acc=65 -> after release no stale out_valid; next ACC 1+1 gives 2.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared types and constants for the multi-lane pipelined adder.
package pa_adder_pipe;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ACC  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   localparam logic RV_C = 1'b0;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_OUT_W = 7;
   localparam int DEF_LANES = 1;

   // One spare bit above the result catches carry-out and borrow.
   function automatic int ext_w(input int out_w);
      return out_w + 1;
   endfunction

endpackage

// File: rtl/adder_pipe_lane.sv
// One adder lane: extend, add/sub/accumulate, clamp or wrap, flag overflow.
module adder_pipe_lane
   import pa_adder_pipe::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  op_e              i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [OUT_W-1:0] o_c,
   output logic             o_ovf
);

   localparam int EW = ext_w(OUT_W);

   logic [EW-1:0]    w_a;
   logic [EW-1:0]    w_b;
   logic [EW-1:0]    w_acc;
   logic [EW-1:0]    w_r;
   logic             w_ovf;
   logic [OUT_W-1:0] w_res;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_c;
   logic             r_ovf;

   assign w_a   = {{(EW-WIDTH){1'b0}}, i_a};
   assign w_b   = {{(EW-WIDTH){1'b0}}, i_b};
   assign w_acc = {1'b0, r_acc};

   always_comb begin
      w_r = '0;
      unique case (i_op)
         OP_ADD:  w_r = w_a + w_b;
         OP_SUB:  w_r = w_a - w_b;
         OP_ACC:  w_r = w_acc + w_a + w_b;
         OP_LOAD: w_r = w_a + w_b;
      endcase
   end

   // Top bit means carry-out for sums and a negative result for SUB.
   assign w_ovf = w_r[OUT_W];

   always_comb begin
      w_res = w_r[OUT_W-1:0];
      if (SATURATE != 0 && w_ovf)
         w_res = (i_op == OP_SUB) ? '0 : '1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= {OUT_W{RV_C}};
         r_c   <= {OUT_W{RV_C}};
         r_ovf <= 1'b0;
      end else if (i_en) begin
         r_c   <= w_res;
         r_ovf <= w_ovf;
         if (i_op == OP_ACC || i_op == OP_LOAD)
            r_acc <= w_res;
      end
   end

   assign o_c   = r_c;
   assign o_ovf = r_ovf;

endmodule

// File: rtl/adder_pipe.sv
// Two-stage valid/ready pipeline wrapping LANES independent adder lanes.
module adder_pipe
   import pa_adder_pipe::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int LANES    = DEF_LANES,
   parameter int SATURATE = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             op,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] c,
   output logic [LANES-1:0]       ovf
);

   logic                   r_s1_v;
   logic                   r_s2_v;
   op_e                    r_s1_op;
   logic [LANES*WIDTH-1:0] r_s1_a;
   logic [LANES*WIDTH-1:0] r_s1_b;
   logic                   w_s1_adv;
   logic                   w_s2_adv;
   logic                   w_s12;

   assign w_s2_adv = !r_s2_v || out_ready;
   assign w_s1_adv = !r_s1_v || w_s2_adv;
   assign w_s12    = r_s1_v && w_s2_adv;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_v  <= 1'b0;
         r_s2_v  <= 1'b0;
         r_s1_op <= OP_ADD;
         r_s1_a  <= '0;
         r_s1_b  <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
               r_s1_op <= op_e'(op);
               r_s1_a  <= a;
               r_s1_b  <= b;
            end
         end
         if (w_s2_adv)
            r_s2_v <= r_s1_v;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      adder_pipe_lane #(
         .WIDTH    (WIDTH),
         .OUT_W    (OUT_W),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .i_en  (w_s12),
         .i_op  (r_s1_op),
         .i_a   (r_s1_a[g*WIDTH +: WIDTH]),
         .i_b   (r_s1_b[g*WIDTH +: WIDTH]),
         .o_c   (c[g*OUT_W +: OUT_W]),
         .o_ovf (ovf[g])
      );
   end

   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_v;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench: wrap and saturate instances side by side against a scoreboard.
module tb_adder_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [1:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_ready;
   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [13:0] c0, c1;
   logic [1:0]  ovf0, ovf1;

   typedef struct packed {
      logic [13:0] c;
      logic [1:0]  ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   acc[2][2];
   int   checks = 0;
   int   fails  = 0;
   int   pops   = 0;
   bit   took;
   logic [13:0] last0, last1;
   logic [1:0]  lovf0, lovf1;

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(4), .OUT_W(7), .LANES(2), .SATURATE(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .op(op), .a(a), .b(b), .out_valid(out_valid0),
      .out_ready(out_ready), .c(c0), .ovf(ovf0)
   );

   adder_pipe #(.WIDTH(4), .OUT_W(7), .LANES(2), .SATURATE(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .op(op), .a(a), .b(b), .out_valid(out_valid1),
      .out_ready(out_ready), .c(c1), .ovf(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_push();
      exp_t e0, e1;
      int av, bv, r, v;
      bit ov;
      e0 = '0;
      e1 = '0;
      for (int s = 0; s < 2; s++) begin
         for (int l = 0; l < 2; l++) begin
            av = int'(a[l*4 +: 4]);
            bv = int'(b[l*4 +: 4]);
            case (op)
               2'b00:   r = av + bv;
               2'b01:   r = av - bv;
               2'b10:   r = acc[s][l] + av + bv;
               default: r = av + bv;
            endcase
            ov = (r > 127) || (r < 0);
            if (s == 1) v = (r > 127) ? 127 : ((r < 0) ? 0 : r);
            else        v = r & 127;
            if (op[1]) acc[s][l] = v;
            if (s == 0) begin
               e0.c[l*7 +: 7] = 7'(v);
               e0.ovf[l]      = ov;
            end else begin
               e1.c[l*7 +: 7] = 7'(v);
               e1.ovf[l]      = ov;
            end
         end
      end
      q0.push_back(e0);
      q1.push_back(e1);
   endtask

   task automatic cyc();
      exp_t e;
      took = 1'b0;
      @(negedge clk);
      if (reset) begin
         if (out_valid0 && out_ready) begin
            pops++;
            if (q0.size() == 0) chk("sb0_extra", 1, 0);
            else begin
               e = q0.pop_front();
               chk("sb0_c", 32'(c0), 32'(e.c));
               chk("sb0_ovf", 32'(ovf0), 32'(e.ovf));
               last0 = c0;
               lovf0 = ovf0;
            end
         end
         if (out_valid1 && out_ready) begin
            pops++;
            if (q1.size() == 0) chk("sb1_extra", 1, 0);
            else begin
               e = q1.pop_front();
               chk("sb1_c", 32'(c1), 32'(e.c));
               chk("sb1_ovf", 32'(ovf1), 32'(e.ovf));
               last1 = c1;
               lovf1 = ovf1;
            end
         end
         if (in_valid && in_ready0) begin
            model_push();
            took = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] o, input logic [7:0] av,
                       input logic [7:0] bv);
      int n = 0;
      in_valid = 1'b1;
      op = o;
      a  = av;
      b  = bv;
      do begin
         cyc();
         n++;
      end while (!took && n < 30);
      if (!took) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
         cyc();
         n++;
      end
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
   endtask

   initial begin
      int k, p;
      logic [13:0] snap;
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < 2; l++) acc[s][l] = 0;
      reset = 1'b0;
      in_valid = 1'b1;
      op = 2'b00;
      a = 8'hff;
      b = 8'hff;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_vld", 32'(out_valid0 | out_valid1), 0);
         chk("rst_c", 32'(c0 | c1), 0);
         chk("rst_ovf", 32'(ovf0 | ovf1), 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_rdy0", 32'(in_ready0), 1);
      chk("rst_rdy1", 32'(in_ready1), 1);
      @(posedge clk);
      #1;

      // Latency: accepted in N, out in N+2.
      in_valid = 1'b1;
      op = 2'b00;
      a = {4'd9, 4'd15};
      b = {4'd3, 4'd15};
      cyc();
      chk("lat_take", 32'(took), 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_n1", 32'(out_valid0), 0);
      @(posedge clk);
      #1;
      p = pops;
      cyc();
      chk("lat_pop", pops - p, 2);
      chk("lat_c", 32'(last0), 32'({7'd12, 7'd30}));
      chk("lat_ovf", 32'(lovf0), 0);

      send(2'b11, {4'd5, 4'd5}, 8'h00);
      for (int i = 0; i < 4; i++) send(2'b10, 8'hff, 8'hff);
      send(2'b10, 8'hff, 8'hff);
      drain();
      chk("acc_wrap", 32'(last0), 32'({7'd27, 7'd27}));
      chk("acc_wovf", 32'(lovf0), 3);
      chk("acc_sat", 32'(last1), 32'({7'd127, 7'd127}));
      chk("acc_sovf", 32'(lovf1), 3);

      send(2'b01, {4'd3, 4'd7}, {4'd7, 4'd3});
      drain();
      chk("sub_wrap", 32'(last0), 32'({7'd124, 7'd4}));
      chk("sub_wovf", 32'(lovf0), 2);
      chk("sub_sat", 32'(last1), 32'({7'd0, 7'd4}));
      chk("sub_sovf", 32'(lovf1), 2);

      // Backpressure: only two beats fit.
      out_ready = 1'b0;
      k = 0;
      snap = '0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         op = 2'b00;
         a = {4'(k + 1), 4'(k + 2)};
         b = {4'(k + 3), 4'(k * 3)};
         cyc();
         if (took) k++;
         if (i == 2) snap = c0;
      end
      chk("bp_count", k, 2);
      chk("bp_rdy", 32'(in_ready0), 0);
      chk("bp_vld", 32'(out_valid0), 1);
      chk("bp_stable", 32'(c0), 32'(snap));
      out_ready = 1'b1;
      #1;
      chk("bp_full_rdy", 32'(in_ready0), 1);
      p = pops;
      while (k < 4) begin
         send(2'b00, {4'(k + 1), 4'(k + 2)}, {4'(k + 3), 4'(k * 3)});
         k++;
      end
      drain();
      chk("bp_pops", pops - p, 8);

      // Reset with beats in flight and acc=65.
      send(2'b11, {4'd5, 4'd5}, 8'h00);
      send(2'b10, 8'hff, 8'hff);
      send(2'b10, 8'hff, 8'hff);
      drain();
      chk("mid_acc", 32'(last0), 32'({7'd65, 7'd65}));
      out_ready = 1'b0;
      send(2'b00, 8'h11, 8'h22);
      send(2'b00, 8'h33, 8'h44);
      #2;
      reset = 1'b0;
      q0.delete();
      q1.delete();
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < 2; l++) acc[s][l] = 0;
      #1;
      chk("mid_rst_vld", 32'(out_valid0 | out_valid1), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mid_no_stale", 32'(out_valid0 | out_valid1), 0);
      end
      send(2'b10, {4'd1, 4'd1}, {4'd1, 4'd1});
      drain();
      chk("mid_acc0", 32'(last0), 32'({7'd2, 7'd2}));
      chk("mid_acc1", 32'(last1), 32'({7'd2, 7'd2}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
